// File: rtl/img_tile_loader.sv
// Raster pixel stream to full-tile parallel output, via a two-bank ping-pong buffer.
// One bank fills while the other is held for the consumer.
module img_tile_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE       = 5
) (
    input  logic                                       clk,
    input  logic                                       nrst,
    input  logic [DATA_WIDTH-1:0]                      pix_in,
    input  logic                                       pix_valid,
    input  logic                                       pix_last,
    output logic                                       pix_ready,
    output logic [TILE-1:0][TILE-1:0][DATA_WIDTH-1:0]  tile_out,
    output logic                                       tile_valid,
    input  logic                                       tile_ready,
    output logic                                       err_frame,
    output logic [15:0]                                tile_count
);

    localparam int IW = (TILE > 1) ? $clog2(TILE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(TILE - 1);

    typedef logic [TILE-1:0][TILE-1:0][DATA_WIDTH-1:0] tile_t;
    localparam tile_t ZERO_TILE = {(TILE*TILE*DATA_WIDTH){1'b0}};

    tile_t          bank_r [2];
    logic [1:0]     full_r;
    logic           wr_sel_r;
    logic           rd_sel_r;
    logic [IW-1:0]  row_r;
    logic [IW-1:0]  col_r;
    logic           err_r;
    logic [15:0]    count_r;

    logic [1:0]     full_nxt_s;
    logic           wr_sel_nxt_s;
    logic           rd_sel_nxt_s;
    logic [IW-1:0]  row_nxt_s;
    logic [IW-1:0]  col_nxt_s;
    logic           err_nxt_s;
    logic [15:0]    count_nxt_s;

    logic           accept_s;
    logic           handoff_s;
    logic           last_pos_s;

    assign accept_s   = pix_valid && !full_r[wr_sel_r];
    assign handoff_s  = full_r[rd_sel_r] && tile_ready;
    assign last_pos_s = (row_r == LAST_IDX) && (col_r == LAST_IDX);

    // Next-state: fill pointer/framing on accept, bank release on handoff (never the same bank).
    always_comb begin
        full_nxt_s   = full_r;
        wr_sel_nxt_s = wr_sel_r;
        rd_sel_nxt_s = rd_sel_r;
        row_nxt_s    = row_r;
        col_nxt_s    = col_r;
        err_nxt_s    = 1'b0;
        count_nxt_s  = count_r;

        if (accept_s) begin
            if (last_pos_s) begin
                full_nxt_s[wr_sel_r] = 1'b1;
                wr_sel_nxt_s         = ~wr_sel_r;
                row_nxt_s            = {IW{1'b0}};
                col_nxt_s            = {IW{1'b0}};
                err_nxt_s            = ~pix_last;
            end else if (pix_last) begin
                // Early last: the partial tile is abandoned and the bank is reused.
                row_nxt_s = {IW{1'b0}};
                col_nxt_s = {IW{1'b0}};
                err_nxt_s = 1'b1;
            end else if (col_r == LAST_IDX) begin
                col_nxt_s = {IW{1'b0}};
                row_nxt_s = row_r + IW'(1);
            end else begin
                col_nxt_s = col_r + IW'(1);
            end
        end else begin
            err_nxt_s = 1'b0;
        end

        if (handoff_s) begin
            full_nxt_s[rd_sel_r] = 1'b0;
            rd_sel_nxt_s         = ~rd_sel_r;
            count_nxt_s          = count_r + 16'd1;
        end else begin
            rd_sel_nxt_s = rd_sel_r;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (nrst) begin
            full_r   <= 2'b00;
            wr_sel_r <= 1'b0;
            rd_sel_r <= 1'b0;
            row_r    <= {IW{1'b0}};
            col_r    <= {IW{1'b0}};
            err_r    <= 1'b0;
            count_r  <= 16'd0;
        end else begin
            full_r   <= full_nxt_s;
            wr_sel_r <= wr_sel_nxt_s;
            rd_sel_r <= rd_sel_nxt_s;
            row_r    <= row_nxt_s;
            col_r    <= col_nxt_s;
            err_r    <= err_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Pixel storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!nrst && accept_s) begin
            bank_r[wr_sel_r][row_r][col_r] <= pix_in;
        end
    end

    assign pix_ready  = !nrst && !full_r[wr_sel_r];
    assign tile_valid = !nrst && full_r[rd_sel_r];
    assign tile_out   = tile_valid ? bank_r[rd_sel_r] : ZERO_TILE;
    assign err_frame  = !nrst && err_r;
    assign tile_count = nrst ? 16'd0 : count_r;

endmodule

// File: tb/tb_img_tile_loader.sv
// Scoreboard bench for img_tile_loader: a tile-level model queues expected tiles,
// a negedge monitor checks every output each cycle and pops on handoff.
module tb_img_tile_loader;

    localparam int DW = 8;
    localparam int T  = 5;
    localparam int N  = T * T;

    logic                          clk = 1'b0;
    logic                          nrst;
    logic [DW-1:0]                 pix_in;
    logic                          pix_valid;
    logic                          pix_last;
    logic                          pix_ready;
    logic [T-1:0][T-1:0][DW-1:0]   tile_out;
    logic                          tile_valid;
    logic                          tile_ready;
    logic                          err_frame;
    logic [15:0]                   tile_count;

    int errors = 0;
    int checks = 0;

    // Reference model: tile occupancy, handoff count, pixels of the tile in progress.
    int             m_held;
    logic [15:0]    m_count;
    logic           m_err;
    logic [DW-1:0]  m_part [$];
    logic [N*DW-1:0] sb_q [$];

    logic           exp_ready;
    logic           exp_valid;
    logic           exp_err;
    logic [15:0]    exp_count;
    logic           check_en = 1'b0;
    logic           acc;

    img_tile_loader #(.DATA_WIDTH(DW), .TILE(T)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_last   (pix_last),
        .pix_ready  (pix_ready),
        .tile_out   (tile_out),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .err_frame  (err_frame),
        .tile_count (tile_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: compare every output mid-cycle, consume the front tile on handoff.
    always @(negedge clk) begin
        if (check_en) begin
            chk("pix_ready", {31'd0, pix_ready}, {31'd0, exp_ready});
            chk("tile_valid", {31'd0, tile_valid}, {31'd0, exp_valid});
            chk("err_frame", {31'd0, err_frame}, {31'd0, exp_err});
            chk("tile_count", {16'd0, tile_count}, {16'd0, exp_count});
            checks++;
            if (exp_valid) begin
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL tile_out: no expected tile queued at %0t", $time);
                end else if (tile_out !== sb_q[0]) begin
                    errors++;
                    $display("FAIL tile_out: got %h want %h", tile_out, sb_q[0]);
                end
                if (tile_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            end else if (tile_out !== {(N*DW){1'b0}}) begin
                errors++;
                $display("FAIL tile_out_zero: got %h want 0", tile_out);
            end
        end
    end

    // One cycle of stimulus; trm: 0 = ready low, 1 = ready high, 2 = random.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic last, input int trm);
        logic            tr;
        logic [N*DW-1:0] t;
        tr = (trm == 2) ? 1'($urandom_range(0, 1)) : (trm == 1);
        @(posedge clk); #1;
        nrst = 1'b0; pix_valid = v; pix_in = d; pix_last = last; tile_ready = tr;
        exp_ready = (m_held < 2);
        exp_valid = (m_held > 0);
        exp_err   = m_err;
        exp_count = m_count;
        check_en  = 1'b1;
        acc   = v && exp_ready;
        m_err = 1'b0;
        if (tr && m_held > 0) begin
            m_held--;
            m_count++;
        end
        if (acc) begin
            m_part.push_back(d);
            if (m_part.size() == N) begin
                for (int i = 0; i < N; i++) t[i*DW +: DW] = m_part[i];
                sb_q.push_back(t);
                m_held++;
                m_err = !last;
                m_part.delete();
            end else if (last) begin
                m_err = 1'b1;
                m_part.delete();
            end
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            nrst = 1'b1; pix_valid = 1'b0; pix_last = 1'b0; tile_ready = 1'b0;
            exp_ready = 1'b0; exp_valid = 1'b0; exp_err = 1'b0; exp_count = 16'd0;
            check_en = 1'b1;
        end
        m_held = 0; m_count = 16'd0; m_err = 1'b0;
        m_part.delete(); sb_q.delete();
    endtask

    task automatic send_px(input logic [DW-1:0] d, input logic last, input int trm);
        int k;
        k = 0;
        do begin
            step(1'b1, d, last, trm);
            k++;
        end while (!acc && k < 300);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_px: pixel %0h not accepted within 300 cycles", d);
        end
    endtask

    task automatic idle(input int n, input int trm);
        repeat (n) step(1'b0, 8'h00, 1'b0, trm);
    endtask

    initial begin
        nrst = 1'b1; pix_valid = 1'b0; pix_in = 8'h00; pix_last = 1'b0; tile_ready = 1'b0;
        m_held = 0; m_count = 16'd0; m_err = 1'b0;
        do_reset(3);

        // Basic tile 1..25
        for (int i = 1; i <= 25; i++) send_px(8'(i), i == 25, 1);
        idle(3, 1);

        // Back-pressure: two tiles stall the third until one handoff
        for (int i = 0; i < 50; i++) send_px(8'(i), (i % 25) == 24, 0);
        idle(5, 0);
        step(1'b0, 8'h00, 1'b0, 1);
        for (int i = 50; i < 75; i++) send_px(8'(i), (i % 25) == 24, 0);
        idle(4, 1);

        // Sustained streaming of 10 tiles
        for (int k = 0; k < 250; k++) send_px(8'(k), (k % 25) == 24, 1);
        idle(3, 1);

        // Early last on pixel 7, then a clean tile
        for (int i = 1; i <= 7; i++) send_px(8'(i), i == 7, 1);
        for (int i = 0; i < 25; i++) send_px(8'(100 + i), i == 24, 1);
        idle(3, 1);

        // Missing last
        for (int i = 0; i < 25; i++) send_px(8'(200 + i), 1'b0, 1);
        idle(3, 1);

        // Reset with one tile pending and a partial tile in progress
        for (int i = 0; i < 25; i++) send_px(8'(30 + i), i == 24, 0);
        for (int i = 0; i < 12; i++) send_px(8'(60 + i), 1'b0, 0);
        do_reset(2);
        for (int i = 0; i < 25; i++) send_px(8'(90 + i), i == 24, 0);
        idle(2, 0);
        idle(2, 1);

        // Randomized traffic
        repeat (1500) step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 40) == 0, 2);
        idle(4, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
